// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | uart_tx_scheduler : round-robin arbiter that serialises 32-bit words     |
// |   into the 8-bit UART TX queue, MSB byte first. UART_TX_SCHED_HDR_EN     |
// |   prefixes each word with a header byte {4'hA, src_id}.                  |
// | Rev 1.0 : initial release                                               |
// +-------------------------------------------------------------------------+
module uart_tx_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [NUM_REQ*32-1:0] i_req_data,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic                  o_enq_txq,
  output logic [7:0]            o_txq_data,
  input  logic                  i_txq_full,
  output logic                  o_busy,
  output logic [ID_WIDTH-1:0]   o_src_id
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_shift;
  logic [2:0]          r_cnt;
  logic [ID_WIDTH-1:0] r_src_id;
  logic [ID_WIDTH-1:0] r_last;
  logic [ID_WIDTH-1:0] w_sel;
  logic [31:0]         w_sel_data;
  logic                w_take;
  logic                w_hdr_phase;
  logic [7:0]          w_byte;

`ifdef UART_TX_SCHED_HDR_EN
  localparam logic [2:0] c_CNT_LOAD = 3'd4;
  assign w_hdr_phase = (r_cnt == 3'd4);
  assign w_byte      = w_hdr_phase ? {4'hA, 4'(r_src_id)} : r_shift[31:24];
`else
  localparam logic [2:0] c_CNT_LOAD = 3'd3;
  assign w_hdr_phase = 1'b0;
  assign w_byte      = r_shift[31:24];
`endif

  // Pick the requester with the smallest circular distance from r_last+1.
  always_comb begin
    int w_dist;
    int w_best;
    w_best     = NUM_REQ;
    w_dist     = 0;
    w_sel      = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - 1 - int'(r_last)) % NUM_REQ;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_sel      = ID_WIDTH'(i);
        w_sel_data = i_req_data[32*i +: 32];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    o_enq_txq   = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|i_req) begin
          w_take      = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        o_busy    = 1'b1;
        o_enq_txq = !i_txq_full;
        if (!i_txq_full && (r_cnt == 3'd0)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reset gates the combinational grant so every output reads zero while held.
  assign o_grant    = (w_take && i_rst) ? (NUM_REQ'(1) << w_sel) : '0;
  assign o_txq_data = o_busy ? w_byte : 8'h00;
  assign o_src_id   = r_src_id;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_src_id <= '0;
      r_last   <= ID_WIDTH'(NUM_REQ - 1);
    end else if (w_take) begin
      r_shift  <= w_sel_data;
      r_cnt    <= c_CNT_LOAD;
      r_src_id <= w_sel;
      r_last   <= w_sel;
    end else if (o_enq_txq) begin
      if (r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (!w_hdr_phase) begin
        r_shift <= {r_shift[23:0], 8'h00};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// Bench for uart_tx_scheduler: queue-driven requesters, round-robin reference
// model and a byte scoreboard checked by an independent monitor.
module tb_uart_tx_scheduler;
  localparam int N = 4;
`ifdef UART_TX_SCHED_HDR_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*32-1:0] req_data;
  logic          full;
  logic [N-1:0]  grant;
  logic          enq;
  logic [7:0]    txd;
  logic          busy;
  logic [1:0]    src_id;

  uart_tx_scheduler #(.NUM_REQ(N)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_req      (req),
    .i_req_data (req_data),
    .o_grant    (grant),
    .o_enq_txq  (enq),
    .o_txq_data (txd),
    .i_txq_full (full),
    .o_busy     (busy),
    .o_src_id   (src_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] stim_q [N][$];
  logic [7:0]  exp_bytes [$];
  int          exp_src [$];
  int          grant_cyc [$];
  logic [N-1:0] grant_oh [$];
  int          enq_cyc [$];
  int          busy_fall [$];
  int          model_last = N - 1;
  logic [N-1:0] gnt_mask = '0;
  int          full_mode = 0;
  int          full_pct = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Spec rule: first requester in circular order after the last grantee.
  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  // Requesters: drop the granted word, present the next queued one.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++)
      if (gnt_mask[i] && stim_q[i].size() > 0) void'(stim_q[i].pop_front());
    gnt_mask = '0;
    for (int i = 0; i < N; i++) begin
      req[i] = (stim_q[i].size() > 0);
      req_data[32*i +: 32] = req[i] ? stim_q[i][0] : 32'h0;
    end
    if (full_mode == 1) full = ($urandom_range(99) < full_pct);
  end

  // Monitor: grant prediction and byte scoreboard.
  always @(negedge clk) begin
    int e;
    logic [N-1:0] eoh;
    logic [31:0] wd;
    logic busy_prev;
    if (!rst_n) begin
      busy_prev = 1'b0;
    end else begin
      if (busy_prev && !busy) busy_fall.push_back(cyc);
      busy_prev = busy;
      if (busy) begin
        chk("no_grant_while_busy", grant, '0);
      end else if (|req) begin
        e = rr_pick(model_last, req);
        eoh = N'(1) << e;
        chk("grant", grant, eoh);
        grant_cyc.push_back(cyc);
        grant_oh.push_back(grant);
        model_last = e;
        gnt_mask[e] = 1'b1;
        wd = (stim_q[e].size() > 0) ? stim_q[e][0] : 32'h0;
        if (NB == 5) begin
          exp_bytes.push_back({4'hA, 4'(e)});
          exp_src.push_back(e);
        end
        for (int b = 3; b >= 0; b--) begin
          exp_bytes.push_back(wd[8*b +: 8]);
          exp_src.push_back(e);
        end
      end
      if (enq) begin
        chk("enq_while_full", full, 1'b0);
        enq_cyc.push_back(cyc);
        chk("byte_expected", exp_bytes.size() > 0, 1'b1);
        if (exp_bytes.size() > 0) begin
          chk("txq_data", txd, exp_bytes.pop_front());
          chk("src_id", src_id, exp_src.pop_front());
        end
      end
    end
  end

  function automatic bit pending();
    bit p = (exp_bytes.size() > 0) || busy || (gnt_mask != 0);
    for (int i = 0; i < N; i++) if (stim_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    repeat (2) begin @(posedge clk); #2; end
    chk({name, "_drain_in_budget"}, n < budget, 1'b1);
  endtask

  // Called at posedge+2; asserts reset mid-cycle and flushes the model.
  task automatic do_reset(input string name);
    #1 rst_n = 1'b0;
    #1;
    chk({name, "_rst_grant"}, grant, '0);
    chk({name, "_rst_enq"}, enq, 1'b0);
    chk({name, "_rst_data"}, txd, 8'h00);
    chk({name, "_rst_busy"}, busy, 1'b0);
    chk({name, "_rst_src"}, src_id, 2'd0);
    exp_bytes.delete();
    exp_src.delete();
    model_last = N - 1;
    gnt_mask = '0;
    for (int i = 0; i < N; i++) stim_q[i].delete();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  initial begin
    int bg, be, bf, t, n;
    logic [N-1:0] order [6];
    rst_n = 1'b0; req = '0; req_data = '0; full = 1'b0;
    #3;
    chk("init_grant", grant, '0);
    chk("init_enq", enq, 1'b0);
    chk("init_data", txd, 8'h00);
    chk("init_busy", busy, 1'b0);
    chk("init_src", src_id, 2'd0);
    release_reset();

    // Single request from source 2
    bg = grant_cyc.size(); be = enq_cyc.size(); bf = busy_fall.size();
    stim_q[2].push_back(32'hDEADBEEF);
    wait_drain("single", 100);
    chk("single_ngrants", grant_cyc.size() - bg, 1);
    chk("single_nbytes", enq_cyc.size() - be, NB);
    if (grant_cyc.size() > bg && enq_cyc.size() >= be + NB && busy_fall.size() > bf) begin
      t = grant_cyc[bg];
      chk("single_grant_oh", grant_oh[bg], 4'b0100);
      for (int k = 0; k < NB; k++) chk("single_byte_cycle", enq_cyc[be+k], t + 1 + k);
      chk("single_busy_fall", busy_fall[bf], t + NB + 1);
    end

    // Backpressure after the second byte
    full_mode = 2;
    be = enq_cyc.size();
    stim_q[0].push_back(32'h11223344);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (enq_cyc.size() < be + 2 && n < 50);
    chk("bp_two_bytes_seen", enq_cyc.size() >= be + 2, 1'b1);
    full = 1'b1;
    repeat (3) @(posedge clk);
    #2 full = 1'b0;
    wait_drain("bp", 100);
    chk("bp_nbytes", enq_cyc.size() - be, NB);
    if (enq_cyc.size() >= be + 3) chk("bp_stall_gap", enq_cyc[be+2] - enq_cyc[be+1], 4);
    full_mode = 0;

    // Arbitration with sources 0,1,3 continuously requesting
    do_reset("arb");
    release_reset();
    bg = grant_cyc.size();
    for (int r = 0; r < 2; r++) begin
      stim_q[0].push_back($urandom);
      stim_q[1].push_back($urandom);
      stim_q[3].push_back($urandom);
    end
    wait_drain("arb", 200);
    order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    chk("arb_ngrants", grant_cyc.size() - bg, 6);
    if (grant_cyc.size() >= bg + 6) begin
      for (int k = 0; k < 6; k++) chk("arb_order", grant_oh[bg+k], order[k]);
      for (int k = 0; k < 5; k++) chk("arb_interval", grant_cyc[bg+k+1] - grant_cyc[bg+k], NB + 1);
    end

    // Back-to-back single source
    bg = grant_cyc.size(); be = enq_cyc.size();
    stim_q[1].push_back(32'hAAAA5555);
    stim_q[1].push_back(32'h12345678);
    wait_drain("b2b", 100);
    chk("b2b_nbytes", enq_cyc.size() - be, 2 * NB);
    if (grant_cyc.size() >= bg + 2)
      chk("b2b_interval", grant_cyc[bg+1] - grant_cyc[bg], NB + 1);

    // Reset mid-word after two bytes of source 1
    be = enq_cyc.size();
    stim_q[1].push_back(32'hCAFEF00D);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (enq_cyc.size() < be + 2 && n < 50);
    chk("mid_busy_before_rst", busy, 1'b1);
    do_reset("mid");
    stim_q[1].push_back(32'hCAFEF00D);
    stim_q[2].push_back(32'h0BADC0DE);
    @(posedge clk); #2;
    chk("mid_grant_held_in_rst", grant, '0);
    bg = grant_cyc.size(); be = enq_cyc.size();
    release_reset();
    wait_drain("mid", 100);
    chk("mid_nbytes", enq_cyc.size() - be, 2 * NB);
    if (grant_cyc.size() > bg) chk("mid_first_grant", grant_oh[bg], 4'b0010);

    // Randomized traffic with random backpressure
    full_mode = 1;
    full_pct = 30;
    for (int batch = 0; batch < 3; batch++) begin
      for (int w = 0; w < 10; w++) begin
        stim_q[$urandom_range(N-1)].push_back($urandom);
        repeat ($urandom_range(3)) @(posedge clk);
        #2;
      end
      wait_drain("rand", 3000);
    end
    full_mode = 0;
    full = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
